// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the core's instruction memory.
// Receives a framed byte stream (4-byte little-endian word count N, 4*N
// payload bytes, 1 XOR checksum byte), writes each assembled little-endian
// word to consecutive word addresses, then releases cpu_rst once the
// checksum matches.
//
// Handshake: a byte transfers on a rising clk edge where in_valid && in_ready.
// in_ready is a pure decode of the registered state (never of in_valid), so a
// byte offered while in_ready is low is simply not consumed.
//
// Optional build macro IMEM_LOADER_TIMEOUT_EN: adds an inter-byte timeout of
// TIMEOUT_CYC cycles while in S_DATA/S_CSUM. Without it the loader waits
// indefinitely in every state.
module imem_loader #(
    parameter int ADDR_W      = 10,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_LEN  = 3'd0,
        S_DATA = 3'd1,
        S_CSUM = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    // Largest legal word count: the whole memory.
    localparam logic [32:0]       CAP     = 33'd1 << ADDR_W;
    localparam logic [ADDR_W-1:0] IDX_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [31:0]         len_q, len_d;
    logic [31:0]         asm_q, asm_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [ADDR_W-1:0]   word_idx_q, word_idx_d;
    logic [7:0]          csum_q, csum_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
`ifdef IMEM_LOADER_TIMEOUT_EN
    logic [31:0]         to_q, to_d;
`endif

    logic                accept;
    logic [31:0]         n_new;
    logic                last_word;

    assign accept = in_valid && in_ready;
    // Header bytes shift in from the top, so after four bytes the first one
    // sits in [7:0].
    assign n_new  = {in_data, len_q[31:8]};
    // Word N-1 is the last; compared at full width so N == 2^ADDR_W works
    // even though the index itself wraps.
    assign last_word = (({{(32-ADDR_W){1'b0}}, word_idx_q}) + 32'd1) == len_q;

    // Outputs decoded from registered state; write port straight from flops.
    assign in_ready   = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
    assign done       = (state_q == S_DONE);
    assign error      = (state_q == S_ERR);
    assign cpu_rst    = (state_q != S_DONE);
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;

    // Next-state logic: frame parsing, word assembly, checksum, write strobe.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        asm_d      = asm_q;
        byte_cnt_d = byte_cnt_q;
        word_idx_d = word_idx_q;
        csum_d     = csum_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;

        case (state_q)
            S_LEN: begin
                if (accept) begin
                    len_d      = n_new;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if ({1'b0, n_new} > CAP) begin
                            state_d = S_ERR;
                        end else if (n_new == 32'd0) begin
                            state_d = S_CSUM;
                        end else begin
                            state_d    = S_DATA;
                            word_idx_d = '0;
                        end
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    asm_d      = {in_data, asm_q[31:8]};
                    csum_d     = csum_q ^ in_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        we_d       = 1'b1;
                        addr_d     = word_idx_q;
                        wdata_d    = asm_d;
                        word_idx_d = word_idx_q + IDX_ONE;
                        if (last_word) begin
                            state_d = S_CSUM;
                        end
                    end
                end
            end
            S_CSUM: begin
                if (accept) begin
                    state_d = (in_data == csum_q) ? S_DONE : S_ERR;
                end
            end
            default: begin
                // S_DONE and S_ERR are terminal until rst.
                state_d = state_q;
            end
        endcase

`ifdef IMEM_LOADER_TIMEOUT_EN
        // Idle counter only runs once the header is in.
        to_d = 32'd0;
        if ((state_q == S_DATA) || (state_q == S_CSUM)) begin
            if (accept) begin
                to_d = 32'd0;
            end else if (to_q == 32'(TIMEOUT_CYC - 1)) begin
                to_d    = 32'd0;
                state_d = S_ERR;
            end else begin
                to_d = to_q + 32'd1;
            end
        end
`endif
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_LEN;
            len_q      <= '0;
            asm_q      <= '0;
            byte_cnt_q <= '0;
            word_idx_q <= '0;
            csum_q     <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
`ifdef IMEM_LOADER_TIMEOUT_EN
            to_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            asm_q      <= asm_d;
            byte_cnt_q <= byte_cnt_d;
            word_idx_q <= word_idx_d;
            csum_q     <= csum_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
`ifdef IMEM_LOADER_TIMEOUT_EN
            to_q       <= to_d;
`endif
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench for imem_loader (ADDR_W=4, TIMEOUT_CYC=50).
// Expected writes are queued as {addr, data} when the 4th byte of a word is
// driven and popped when imem_we is seen. Timeout steps are built only when
// IMEM_LOADER_TIMEOUT_EN is defined.
module tb_imem_loader;

    localparam int AW = 4;
    localparam int TO = 50;
    localparam int W  = AW + 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_rst;
    logic          done;
    logic          error;

    int            total = 0;
    int            bad   = 0;
    logic [W-1:0]  exp_q[$];
    logic [7:0]    pay[$];
    logic [W-1:0]  mon_exp;

    imem_loader #(.ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .done       (done),
        .error      (error)
    );

    // Clock and global time limit.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every strobe must match the head of the expected queue,
    // and done must not already be up while a write is still visible.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL write_unexpected observed=%0h expected=none", {imem_addr, imem_wdata});
            end
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                total++;
                assert ({imem_addr, imem_wdata} === mon_exp) else begin
                    bad++;
                    $error("FAIL write observed=%0h expected=%0h", {imem_addr, imem_wdata}, mon_exp);
                end
            end
            total++;
            assert (done === 1'b0) else begin
                bad++;
                $error("FAIL done_with_we observed=%0h expected=0", done);
            end
        end
    end

    // Driver tasks: inputs change on the falling edge, transfer on the rising edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] b, input bit gap);
        if (gap) idle($urandom_range(0, 2));
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        chk("in_ready_on_send", in_ready, 32'd1);
    endtask

    task automatic send_header(input logic [31:0] n, input bit gap);
        for (int k = 0; k < 4; k++) send(n[8*k +: 8], gap);
    endtask

    task automatic send_payload(input int nb, input bit gap);
        logic [AW-1:0] a;
        for (int i = 0; i < nb; i++) begin
            if (i % 4 == 3) begin
                a = AW'(i / 4);
                exp_q.push_back({a, pay[i], pay[i-1], pay[i-2], pay[i-3]});
            end
            send(pay[i], gap);
        end
    endtask

    function automatic logic [7:0] pay_xor();
        logic [7:0] x = 8'h00;
        foreach (pay[i]) x ^= pay[i];
        return x;
    endfunction

    task automatic fill_pay(input int nwords);
        pay.delete();
        for (int i = 0; i < 4 * nwords; i++) pay.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic expect_end(input string tag, input logic d, input logic e);
        chk({tag, "_done"}, done, 32'(d));
        chk({tag, "_error"}, error, 32'(e));
        chk({tag, "_cpu_rst"}, cpu_rst, 32'(!d));
        chk({tag, "_in_ready"}, in_ready, 32'd0);
        chk({tag, "_pending_writes"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset values.
        chk("rst_in_ready", in_ready, 32'd1);
        chk("rst_imem_we", imem_we, 32'd0);
        chk("rst_imem_addr", imem_addr, 32'd0);
        chk("rst_imem_wdata", imem_wdata, 32'd0);
        chk("rst_cpu_rst", cpu_rst, 32'd1);
        chk("rst_done", done, 32'd0);
        chk("rst_error", error, 32'd0);

        // Two-word image, back-to-back bytes, correct checksum.
        pay = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        send_header(32'd2, 1'b0);
        send_payload(8, 1'b0);
        send(pay_xor(), 1'b0);
        idle(1);
        expect_end("good2", 1'b1, 1'b0);
        idle(3);
        chk("good2_done_sticky", done, 32'd1);

        // Same image, wrong checksum: words still land, then error.
        do_reset();
        send_header(32'd2, 1'b0);
        send_payload(8, 1'b0);
        send(8'h94, 1'b0);
        idle(1);
        expect_end("badsum", 1'b0, 1'b1);

        // Empty image.
        do_reset();
        pay.delete();
        send_header(32'd0, 1'b0);
        send(8'h00, 1'b0);
        idle(1);
        expect_end("empty", 1'b1, 1'b0);

        // Oversize header: error right after the 4th byte, later bytes ignored.
        do_reset();
        send_header(32'd17, 1'b0);
        idle(1);
        chk("ovf_error", error, 32'd1);
        chk("ovf_in_ready", in_ready, 32'd0);
        repeat (3) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'h5a;
        end
        idle(1);
        expect_end("ovf", 1'b0, 1'b1);

        // Full-capacity image: last address is all-ones.
        do_reset();
        fill_pay(16);
        send_header(32'd16, 1'b0);
        send_payload(64, 1'b0);
        send(pay_xor(), 1'b0);
        idle(1);
        expect_end("full", 1'b1, 1'b0);

        // Random gaps, reset in the middle of the payload, then a fresh image.
        do_reset();
        fill_pay(3);
        send_header(32'd3, 1'b1);
        send_payload(6, 1'b1);
        idle(2);
        chk("midrst_pending_writes", exp_q.size(), 32'd0);
        do_reset();
        chk("midrst_in_ready", in_ready, 32'd1);
        chk("midrst_cpu_rst", cpu_rst, 32'd1);
        chk("midrst_imem_we", imem_we, 32'd0);
        chk("midrst_done", done, 32'd0);
        chk("midrst_error", error, 32'd0);
        fill_pay(3);
        send_header(32'd3, 1'b1);
        send_payload(12, 1'b1);
        send(pay_xor(), 1'b1);
        idle(1);
        expect_end("reload", 1'b1, 1'b0);

`ifdef IMEM_LOADER_TIMEOUT_EN
        // Stall before the header is harmless.
        do_reset();
        idle(60);
        chk("to_hdr_error", error, 32'd0);
        chk("to_hdr_in_ready", in_ready, 32'd1);
        // Stall mid-payload trips after TO idle cycles.
        fill_pay(2);
        send_header(32'd2, 1'b0);
        send(pay[0], 1'b0);
        send(pay[1], 1'b0);
        idle(TO);
        chk("to_before_limit", error, 32'd0);
        idle(1);
        chk("to_error", error, 32'd1);
        chk("to_cpu_rst", cpu_rst, 32'd1);
        chk("to_in_ready", in_ready, 32'd0);
`endif

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
